fewcore_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding unit for the fewcore pipeline; generalises the 2-bit mini-scoreboard to N stages.

---
 rtl/fewcore_pkg.sv | 27 ++
 rtl/fewcore_fwd_match.sv | 34 +++
 rtl/fewcore_scoreboard.sv | 107 ++++++++++
 tb/tb_fewcore_scoreboard.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fewcore_pkg.sv
// Shared definitions for the fewcore hazard/forwarding logic and the execute-stage operand mux.
// Stage records carry a fixed-width rd field so one record type serves every register-file size.
package fewcore_pkg;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // Widest register index a stage record can hold (up to 256 architectural registers).
  localparam int FC_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [FC_RD_W-1:0] rd;
    logic               is_load;
  } stage_rec_t;

  // Selects span 0 (register file) plus one code per tracked stage.
  function automatic int sel_width(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

  // A record supplies source index src when it is live and targets that register.
  function automatic logic rec_matches(input stage_rec_t rec, input logic [FC_RD_W-1:0] src);
    return rec.valid && (rec.rd == src);
  endfunction

endpackage

// File: rtl/fewcore_fwd_match.sv
// Priority match of one source register index against all tracked stage records.
// The youngest (lowest-numbered) live stage writing the source wins; x0 never matches.
module fewcore_fwd_match
  import fewcore_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
) (
  input  logic [ADDR_W-1:0]      src,
  input  stage_rec_t [STAGES-1:0] recs,
  output logic [SEL_W-1:0]       sel,
  output logic                   hit_is_load
);

  logic [FC_RD_W-1:0] src_ext;

  assign src_ext = FC_RD_W'(src);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    sel         = SEL_W'(FWD_RF);
    hit_is_load = 1'b0;
    if (src != '0) begin
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (rec_matches(recs[k], src_ext)) begin
          sel         = SEL_W'(k + 1);
          hit_is_load = recs[k].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/fewcore_scoreboard.sv
// Hazard/forwarding unit: tracks rd of every in-flight instruction over STAGES stages and
// produces per-operand forward selects, a load-use stall, a busy vector and a stall counter.
module fewcore_scoreboard
  import fewcore_pkg::*;
#(
  parameter int NREGS      = 32,
  parameter int ADDR_W     = 5,
  parameter int STAGES     = 2,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = sel_width(STAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_rd_we,
  input  logic              issue_is_load,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel_rs1,
  output logic [SEL_W-1:0]  fwd_sel_rs2,
  output logic [NREGS-1:0]  busy,
  output logic [CNT_W-1:0]  stall_count
);

  // Index 0 is stage 1 (execute); index STAGES-1 is the retire stage.
  stage_rec_t [STAGES-1:0] stage_q;
  stage_rec_t              issue_rec;
  logic [CNT_W-1:0]        count_q;
  logic                    rs1_is_load;
  logic                    rs2_is_load;
  logic                    rs1_load_use;
  logic                    rs2_load_use;

  fewcore_fwd_match #(
    .STAGES (STAGES),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_match_rs1 (
    .src         (issue_rs1),
    .recs        (stage_q),
    .sel         (fwd_sel_rs1),
    .hit_is_load (rs1_is_load)
  );

  fewcore_fwd_match #(
    .STAGES (STAGES),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_match_rs2 (
    .src         (issue_rs2),
    .recs        (stage_q),
    .sel         (fwd_sel_rs2),
    .hit_is_load (rs2_is_load)
  );

  // A load still short of LOAD_READY has no data yet; a younger ALU match already shadowed it.
  always_comb begin
    rs1_load_use = rs1_is_load && (fwd_sel_rs1 != '0) && (int'(fwd_sel_rs1) < LOAD_READY);
    rs2_load_use = rs2_is_load && (fwd_sel_rs2 != '0) && (int'(fwd_sel_rs2) < LOAD_READY);
    stall        = issue_valid && !flush && (rs1_load_use || rs2_load_use);
  end

  // x0 writers, bubbles, stalled and flushed issues all enter stage 1 as invalid records.
  always_comb begin
    issue_rec = '{
      valid:   issue_valid && issue_rd_we && (issue_rd != '0) && !stall && !flush,
      rd:      FC_RD_W'(issue_rd),
      is_load: issue_is_load
    };
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      for (int k = STAGES - 1; k > 0; k--) begin
        stage_q[k] <= stage_q[k-1];
      end
      stage_q[0] <= issue_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (stall && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign stall_count = count_q;

  always_comb begin
    busy = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stage_q[k].valid) begin
        busy[ADDR_W'(stage_q[k].rd)] = 1'b1;
      end
    end
    busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_fewcore_scoreboard.sv
// Scoreboard bench for fewcore_scoreboard: two configurations share one stimulus stream and are
// checked against a history-based reference model of the in-flight writers.
module tb_fewcore_scoreboard;

  localparam int SA = 2, LRA = 2, CWA = 16;
  localparam int SB = 4, LRB = 3, CWB = 4;
  localparam int W  = 57;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic issue_valid = 1'b0;
  logic [4:0] issue_rd = '0;
  logic issue_rd_we = 1'b0;
  logic issue_is_load = 1'b0;
  logic [4:0] issue_rs1 = '0;
  logic [4:0] issue_rs2 = '0;
  logic flush = 1'b0;

  logic stall_a, stall_b;
  logic [1:0] sel1_a, sel2_a;
  logic [2:0] sel1_b, sel2_b;
  logic [31:0] busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [3:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fewcore_scoreboard #(.NREGS(32), .ADDR_W(5), .STAGES(SA), .LOAD_READY(LRA), .CNT_W(CWA)) dut_a (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .flush(flush), .stall(stall_a), .fwd_sel_rs1(sel1_a),
    .fwd_sel_rs2(sel2_a), .busy(busy_a), .stall_count(cnt_a)
  );

  fewcore_scoreboard #(.NREGS(32), .ADDR_W(5), .STAGES(SB), .LOAD_READY(LRB), .CNT_W(CWB)) dut_b (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .flush(flush), .stall(stall_b), .fwd_sel_rs1(sel1_b),
    .fwd_sel_rs2(sel2_b), .busy(busy_b), .stall_count(cnt_b)
  );

  // ---------------- reference model ----------------
  // hist[i][k] is the instruction issued k cycles ago that writes a register (valid=0 for none).
  bit hv[2][1:7];
  int hrd[2][1:7];
  bit hl[2][1:7];
  int mcnt[2];

  function automatic int model_sel(input int inst, input int ns, input int src);
    if (src == 0) return 0;
    for (int k = 1; k <= ns; k++)
      if (hv[inst][k] && hrd[inst][k] == src) return k;
    return 0;
  endfunction

  function automatic bit model_stall(input int inst, input int ns, input int lr,
                                     input bit v, input bit fl, input int rs1, input int rs2);
    int k1, k2;
    if (!v || fl) return 1'b0;
    k1 = model_sel(inst, ns, rs1);
    k2 = model_sel(inst, ns, rs2);
    return (k1 != 0 && hl[inst][k1] && k1 < lr) || (k2 != 0 && hl[inst][k2] && k2 < lr);
  endfunction

  function automatic logic [31:0] model_busy(input int inst, input int ns);
    logic [31:0] b = '0;
    for (int k = 1; k <= ns; k++)
      if (hv[inst][k]) b[hrd[inst][k]] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  function automatic logic [W-1:0] model_expect(input int inst, input int ns, input int lr,
      input bit v, input bit fl, input int rs1, input int rs2);
    logic s = model_stall(inst, ns, lr, v, fl, rs1, rs2);
    return {s, 4'(model_sel(inst, ns, rs1)), 4'(model_sel(inst, ns, rs2)),
            model_busy(inst, ns), 16'(mcnt[inst])};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0;
      for (int k = 1; k <= 7; k++) begin
        hv[i][k] = 1'b0; hrd[i][k] = 0; hl[i][k] = 1'b0;
      end
    end
  endtask

  task automatic model_advance(input int inst, input int ns, input int cw, input bit st,
      input bit v, input int rd, input bit we, input bit ld, input bit fl);
    for (int k = ns; k > 1; k--) begin
      hv[inst][k] = hv[inst][k-1]; hrd[inst][k] = hrd[inst][k-1]; hl[inst][k] = hl[inst][k-1];
    end
    hv[inst][1]  = v && we && rd != 0 && !st && !fl;
    hrd[inst][1] = rd;
    hl[inst][1]  = ld;
    if (st && mcnt[inst] < (1 << cw) - 1) mcnt[inst] = mcnt[inst] + 1;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit v, input int rd, input bit we, input bit ld,
                       input int rs1, input int rs2, input bit fl);
    bit st_a, st_b;
    issue_valid = v; issue_rd = 5'(rd); issue_rd_we = we; issue_is_load = ld;
    issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2); flush = fl;
    st_a = model_stall(0, SA, LRA, v, fl, rs1, rs2);
    st_b = model_stall(1, SB, LRB, v, fl, rs1, rs2);
    if (reset) begin
      exp_q_a.push_back(model_expect(0, SA, LRA, v, fl, rs1, rs2));
      exp_q_b.push_back(model_expect(1, SB, LRB, v, fl, rs1, rs2));
    end
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      model_advance(0, SA, CWA, st_a, v, rd, we, ld, fl);
      model_advance(1, SB, CWB, st_b, v, rd, we, ld, fl);
    end
    #1;
  endtask

  task automatic idle(input int rs1, input int rs2);
    cycle(1'b0, 0, 1'b0, 1'b0, rs1, rs2, 1'b0);
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2);
    cycle(1'b1, rd, 1'b1, 1'b0, rs1, rs2, 1'b0);
  endtask

  task automatic load(input int rd, input int rs1, input bit fl);
    cycle(1'b1, rd, 1'b1, 1'b1, rs1, 0, fl);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) idle(0, 0);
    reset = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got stall=%0b sel1=%0d sel2=%0d busy=%h cnt=%0d, want stall=%0b sel1=%0d sel2=%0d busy=%h cnt=%0d",
               name, $time, act[56], act[55:52], act[51:48], act[47:16], act[15:0],
               exp[56], exp[55:52], exp[51:48], exp[47:16], exp[15:0]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q_a.size() > 0)
      compare("cfg_s2", {stall_a, 4'(sel1_a), 4'(sel2_a), busy_a, cnt_a}, exp_q_a.pop_front());
    if (exp_q_b.size() > 0)
      compare("cfg_s4", {stall_b, 4'(sel1_b), 4'(sel2_b), busy_b, 16'(cnt_b)}, exp_q_b.pop_front());
  end

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    #1;
    do_reset(2);
    // single writer, then observe busy with unrelated sources
    alu(5, 1, 2);
    idle(1, 2);
    idle(5, 5);
    // back-to-back, one bubble, two bubbles
    alu(5, 1, 2); alu(6, 5, 5);
    alu(5, 0, 0); idle(0, 0); alu(6, 5, 5);
    alu(5, 0, 0); idle(0, 0); idle(0, 0); alu(6, 5, 5);
    // load-use, with re-presentation
    load(7, 2, 1'b0);
    for (int i = 0; i < 3; i++) alu(8, 7, 1);
    // younger ALU write shadows the load
    load(7, 2, 1'b0); alu(7, 3, 4); alu(10, 7, 7);
    // flushed load, x0 writer
    load(9, 1, 1'b1); alu(11, 9, 9); idle(9, 0);
    alu(0, 1, 2); alu(12, 0, 0);
    // rd==rs at issue
    alu(13, 13, 13); alu(14, 13, 0);
    // deep load-use
    load(3, 0, 1'b0);
    for (int i = 0; i < 4; i++) alu(15, 3, 3);
    // flush at a stalling issue
    load(4, 0, 1'b0); cycle(1'b1, 16, 1'b1, 1'b0, 4, 0, 1'b1);
    // reset in the middle of a stall
    load(4, 0, 1'b0);
    reset = 1'b0; alu(17, 4, 4);
    reset = 1'b1; alu(17, 4, 4); idle(4, 17);
    // drive the small counter to saturation
    for (int i = 0; i < 8; i++) begin
      load(3, 0, 1'b0); alu(18, 3, 0); alu(18, 0, 3); alu(18, 3, 3);
    end
    // randomized traffic over a small register window to force hazards
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 999) == 0) do_reset(1);
    end
    idle(0, 0);
    @(negedge clk); #1;
    n_cmp++;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", exp_q_a.size(), exp_q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
